// File: rtl/att_sched_pkg.sv
// Shared types and constants for the attention weight scheduler.
// Stream indices double as bit positions in the request/grant vectors.
package att_sched_pkg;

    localparam int NUM_STREAMS = 3;

    // Weight streams feeding the attention core
    typedef enum logic [1:0] {
        STREAM_Q = 2'd0,
        STREAM_K = 2'd1,
        STREAM_V = 2'd2
    } stream_e;

    // Job-level control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Counter width for a modulus of n, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for a shared single-port resource.
// Grants at most one requester per cycle. The search starts just after the
// most recently granted requester, so after reset or clear the order is 0, 1, 2, ...
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] last;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Pick the first requester after the last granted one, wrapping around
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PTR_W'((int'(last) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Remember the last granted requester; park on N-1 so index 0 is served first
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values, matching the hardware.
        if (rst) begin
            last <= PTR_W'(N - 1);
        end else if (clear) begin
            last <= PTR_W'(N - 1);
        end else begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    last <= PTR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/fixed_att_weight_scheduler.sv
// Streams Q, K and V weight tiles from one shared single-port parameter memory
// into the attention core. Each stream walks tile 0..TILES-1 once per pass,
// requests the memory when it has nothing in flight and an empty output slot,
// and presents the returned tile on a valid/ready port.
module fixed_att_weight_scheduler
    import att_sched_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int W_PARALLELISM      = 2,
    parameter int W_SIZE             = 3,
    parameter int W_NUM_PARALLELISM  = 3,
    parameter int IN_DEPTH           = 3,
    parameter int IN_NUM_PARALLELISM = 2,
    parameter int ADDR_WIDTH         = 8,
    parameter int Q_BASE             = 0,
    parameter int K_BASE             = 9,
    parameter int V_BASE             = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata [W_PARALLELISM*W_SIZE],
    output logic [DATA_WIDTH-1:0] weight_q [W_PARALLELISM*W_SIZE],
    output logic                  weight_q_valid,
    input  logic                  weight_q_ready,
    output logic [DATA_WIDTH-1:0] weight_k [W_PARALLELISM*W_SIZE],
    output logic                  weight_k_valid,
    input  logic                  weight_k_ready,
    output logic [DATA_WIDTH-1:0] weight_v [W_PARALLELISM*W_SIZE],
    output logic                  weight_v_valid,
    input  logic                  weight_v_ready
);

    localparam int ELEMS  = W_PARALLELISM * W_SIZE;
    localparam int TILES  = W_NUM_PARALLELISM * IN_DEPTH;
    localparam int PASSES = IN_NUM_PARALLELISM;
    localparam int TILE_W = clog2_min1(TILES);
    localparam int PASS_W = clog2_min1(PASSES);

    state_e                  state;
    logic [TILE_W-1:0]       tile       [NUM_STREAMS];
    logic [PASS_W-1:0]       pass       [NUM_STREAMS];
    logic [DATA_WIDTH-1:0]   slot_data  [NUM_STREAMS][ELEMS];
    logic [NUM_STREAMS-1:0]  finished;
    logic [NUM_STREAMS-1:0]  pending;
    logic [NUM_STREAMS-1:0]  slot_valid;
    logic [NUM_STREAMS-1:0]  ready;
    logic [NUM_STREAMS-1:0]  req;
    logic [NUM_STREAMS-1:0]  grant;
    logic                    start_accept;
    logic                    all_empty;

    function automatic logic [ADDR_WIDTH-1:0] base_addr(input int s);
        if (s == int'(STREAM_Q)) begin
            return ADDR_WIDTH'(Q_BASE);
        end else if (s == int'(STREAM_K)) begin
            return ADDR_WIDTH'(K_BASE);
        end else begin
            return ADDR_WIDTH'(V_BASE);
        end
    endfunction

    assign start_accept = (state == ST_IDLE) && start;
    assign ready        = {weight_v_ready, weight_k_ready, weight_q_ready};
    assign all_empty    = (pending == '0) && (slot_valid == '0);

    // Requests depend on registered state only, so no ready reaches the memory port in the same cycle.
    assign req = {NUM_STREAMS{state == ST_RUN}} & ~finished & ~pending & ~slot_valid;

    rr_arbiter #(
        .N(NUM_STREAMS)
    ) u_arbiter (
        .clk  (clk),
        .rst  (rst),
        .clear(start_accept),
        .req  (req),
        .grant(grant)
    );

    // Drive the memory port from the granted stream's next tile address
    always_comb begin
        mem_rd_en = |grant;
        mem_addr  = '0;
        for (int s = 0; s < NUM_STREAMS; s++) begin
            if (grant[s]) begin
                mem_addr = base_addr(s) + ADDR_WIDTH'(tile[s]);
            end
        end
    end

    // Advance tile/pass counters on each grant; mark a stream finished after its last read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_STREAMS; s++) begin
                tile[s] <= '0;
                pass[s] <= '0;
            end
            finished <= '0;
        end else if (start_accept) begin
            for (int s = 0; s < NUM_STREAMS; s++) begin
                tile[s] <= '0;
                pass[s] <= '0;
            end
            finished <= '0;
        end else begin
            for (int s = 0; s < NUM_STREAMS; s++) begin
                if (grant[s]) begin
                    if (tile[s] == TILE_W'(TILES - 1)) begin
                        tile[s] <= '0;
                        if (pass[s] == PASS_W'(PASSES - 1)) begin
                            finished[s] <= 1'b1;
                        end else begin
                            pass[s] <= pass[s] + 1'b1;
                        end
                    end else begin
                        tile[s] <= tile[s] + 1'b1;
                    end
                end
            end
        end
    end

    // Track the in-flight read and the one-entry output slot of each stream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            slot_valid <= '0;
            // NOTE: slot data is an explicit reset target so the weight ports read zero out of reset and after an aborted job.
            for (int s = 0; s < NUM_STREAMS; s++) begin
                for (int e = 0; e < ELEMS; e++) begin
                    slot_data[s][e] <= '0;
                end
            end
        end else begin
            for (int s = 0; s < NUM_STREAMS; s++) begin
                if (grant[s]) begin
                    pending[s] <= 1'b1;
                end else if (pending[s]) begin
                    // Read data arrives the cycle after the grant; the slot is empty by construction
                    pending[s]    <= 1'b0;
                    slot_valid[s] <= 1'b1;
                    slot_data[s]  <= mem_rdata;
                end else if (slot_valid[s] && ready[s]) begin
                    slot_valid[s] <= 1'b0;
                end
            end
        end
    end

    // Job control: run until every stream has issued its last read, then drain the slots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (&finished) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (all_empty) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign weight_q       = slot_data[int'(STREAM_Q)];
    assign weight_k       = slot_data[int'(STREAM_K)];
    assign weight_v       = slot_data[int'(STREAM_V)];
    assign weight_q_valid = slot_valid[int'(STREAM_Q)];
    assign weight_k_valid = slot_valid[int'(STREAM_K)];
    assign weight_v_valid = slot_valid[int'(STREAM_V)];

endmodule

// File: tb/tb_fixed_att_weight_scheduler.sv
// Directed bench for fixed_att_weight_scheduler. The memory model returns
// element e of word a as a*8+e, so every accepted tile identifies its address.
`timescale 1ns/1ps
module tb_fixed_att_weight_scheduler;

    localparam int DW         = 8;
    localparam int AW         = 8;
    localparam int ELEMS      = 6;
    localparam int TILES      = 9;
    localparam int PER_STREAM = 18;
    localparam int TOTAL_RD   = 54;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata [ELEMS];
    logic [DW-1:0] weight_q [ELEMS];
    logic [DW-1:0] weight_k [ELEMS];
    logic [DW-1:0] weight_v [ELEMS];
    logic          weight_q_valid, weight_k_valid, weight_v_valid;
    logic          weight_q_ready, weight_k_ready, weight_v_ready;

    fixed_att_weight_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .weight_q      (weight_q),
        .weight_q_valid(weight_q_valid),
        .weight_q_ready(weight_q_ready),
        .weight_k      (weight_k),
        .weight_k_valid(weight_k_valid),
        .weight_k_ready(weight_k_ready),
        .weight_v      (weight_v),
        .weight_v_valid(weight_v_valid),
        .weight_v_ready(weight_v_ready)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, data encodes the address
    always @(posedge clk) begin
        if (mem_rd_en) begin
            for (int e = 0; e < ELEMS; e++) begin
                mem_rdata[e] <= {mem_addr[4:0], 3'(e)};
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard state
    int rd_idx [3];
    int acc    [3];
    int rd_total;
    int done_cnt;
    int mon_s;

    function automatic int base_of(input int s);
        return s * TILES;
    endfunction

    function automatic int stream_of(input int a);
        return (a < 9) ? 0 : ((a < 18) ? 1 : 2);
    endfunction

    task automatic clear_sb();
        for (int s = 0; s < 3; s++) begin
            rd_idx[s] = 0;
            acc[s]    = 0;
        end
        rd_total = 0;
        done_cnt = 0;
    endtask

    task automatic observe(input int s, input logic v, input logic r,
                           input logic [DW-1:0] d0, input logic [DW-1:0] dl);
        int exp0;
        if (v && r) begin
            exp0 = (base_of(s) + acc[s] % TILES) * 8;
            check($sformatf("s%0d_tile%0d_e0", s, acc[s]), int'(d0), exp0);
            check($sformatf("s%0d_tile%0d_elast", s, acc[s]), int'(dl), exp0 + ELEMS - 1);
            acc[s]++;
        end
    endtask

    // Monitor: read address order per stream, accepted tile contents, done pulses
    always @(negedge clk) begin
        if (mem_rd_en) begin
            mon_s = stream_of(int'(mem_addr));
            check($sformatf("rd_addr_s%0d_n%0d", mon_s, rd_idx[mon_s]), int'(mem_addr),
                  base_of(mon_s) + rd_idx[mon_s] % TILES);
            rd_idx[mon_s]++;
            rd_total++;
        end
        observe(0, weight_q_valid, weight_q_ready, weight_q[0], weight_q[ELEMS-1]);
        observe(1, weight_k_valid, weight_k_ready, weight_k[0], weight_k[ELEMS-1]);
        observe(2, weight_v_valid, weight_v_ready, weight_v[0], weight_v[ELEMS-1]);
        if (done) begin
            done_cnt++;
        end
    end

    task automatic set_ready(input logic q, input logic k, input logic v);
        weight_q_ready = q;
        weight_k_ready = k;
        weight_v_ready = v;
    endtask

    // start is high for exactly one cycle (cycle 0); returns early in cycle 1
    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check({tag, "_busy_at_done"}, int'(busy), 0);
            end
        end
        check({tag, "_done_seen"}, int'(seen), 1);
    endtask

    task automatic check_totals(input string tag);
        check({tag, "_rd_total"}, rd_total, TOTAL_RD);
        check({tag, "_acc_q"}, acc[0], PER_STREAM);
        check({tag, "_acc_k"}, acc[1], PER_STREAM);
        check({tag, "_acc_v"}, acc[2], PER_STREAM);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_ready(1'b0, 1'b0, 1'b0);
        clear_sb();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_en", int'(mem_rd_en), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_q_valid", int'(weight_q_valid), 0);
        check("rst_k_valid", int'(weight_k_valid), 0);
        check("rst_v_valid", int'(weight_v_valid), 0);
        check("rst_q_data", int'(weight_q[0]), 0);
        check("rst_v_data", int'(weight_v[ELEMS-1]), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full job, all consumers always ready
        set_ready(1'b1, 1'b1, 1'b1);
        clear_sb();
        pulse_start();
        @(negedge clk);
        check("c1_rd_en", int'(mem_rd_en), 1);
        check("c1_addr", int'(mem_addr), 0);
        check("c1_busy", int'(busy), 1);
        @(negedge clk);
        check("c2_addr", int'(mem_addr), 9);
        check("c2_q_valid", int'(weight_q_valid), 0);
        @(negedge clk);
        check("c3_addr", int'(mem_addr), 18);
        check("c3_q_valid", int'(weight_q_valid), 1);
        wait_done(400, "full");
        repeat (5) @(negedge clk);
        check_totals("full");
        check("full_done_cnt", done_cnt, 1);

        // K consumer stalled: Q and V must still complete
        @(posedge clk);
        #1 set_ready(1'b1, 1'b0, 1'b1);
        clear_sb();
        pulse_start();
        repeat (20) @(negedge clk);
        check("kstall_early_k_valid", int'(weight_k_valid), 1);
        check("kstall_early_k_data", int'(weight_k[0]), 72);
        repeat (50) @(negedge clk);
        check("kstall_acc_q", acc[0], PER_STREAM);
        check("kstall_acc_v", acc[2], PER_STREAM);
        check("kstall_k_reads", rd_idx[1], 1);
        check("kstall_k_valid", int'(weight_k_valid), 1);
        check("kstall_k_e0", int'(weight_k[0]), 72);
        check("kstall_k_elast", int'(weight_k[ELEMS-1]), 77);
        check("kstall_busy", int'(busy), 1);
        @(posedge clk);
        #1 set_ready(1'b1, 1'b1, 1'b1);
        wait_done(300, "kstall");
        repeat (3) @(negedge clk);
        check_totals("kstall");
        check("kstall_done_cnt", done_cnt, 1);

        // Random backpressure on all three streams
        @(posedge clk);
        #1 clear_sb();
        pulse_start();
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 3000 && !seen; i++) begin
                @(posedge clk);
                #1 {weight_q_ready, weight_k_ready, weight_v_ready} = 3'($urandom_range(0, 7));
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                end
            end
            check("rand_done_seen", int'(seen), 1);
        end
        @(posedge clk);
        #1 set_ready(1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check_totals("rand");
        check("rand_done_cnt", done_cnt, 1);

        // start re-pulsed while running is ignored
        @(posedge clk);
        #1 clear_sb();
        pulse_start();
        repeat (10) @(posedge clk);
        pulse_start();
        wait_done(400, "restart");
        repeat (10) @(negedge clk);
        check_totals("restart");
        check("restart_done_cnt", done_cnt, 1);
        check("restart_busy_after", int'(busy), 0);

        // Reset in the middle of a job
        @(posedge clk);
        #1 clear_sb();
        pulse_start();
        repeat (9) @(posedge clk);
        #2 check("midrst_busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_rd_en", int'(mem_rd_en), 0);
        check("midrst_addr", int'(mem_addr), 0);
        check("midrst_q_valid", int'(weight_q_valid), 0);
        check("midrst_k_valid", int'(weight_k_valid), 0);
        check("midrst_v_valid", int'(weight_v_valid), 0);
        check("midrst_k_data", int'(weight_k[0]), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_sb();
        @(negedge clk);
        check("postrst_q_valid", int'(weight_q_valid), 0);
        check("postrst_rd_en", int'(mem_rd_en), 0);
        pulse_start();
        @(negedge clk);
        check("postrst_c1_rd_en", int'(mem_rd_en), 1);
        check("postrst_c1_addr", int'(mem_addr), 0);
        wait_done(400, "postrst");
        repeat (3) @(negedge clk);
        check_totals("postrst");
        check("postrst_done_cnt", done_cnt, 1);

        // Only the V slot left occupied: done must wait for it
        @(posedge clk);
        #1 set_ready(1'b1, 1'b1, 1'b0);
        clear_sb();
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (acc[0] == PER_STREAM && acc[1] == PER_STREAM) break;
        end
        check("vdrain_qk_finished", acc[0] + acc[1], 2 * PER_STREAM);
        weight_v_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (acc[2] >= PER_STREAM - 1) begin
                weight_v_ready = 1'b0;
                break;
            end
        end
        check("vdrain_v_reached_17", acc[2], PER_STREAM - 1);
        repeat (20) @(negedge clk);
        check("vdrain_busy", int'(busy), 1);
        check("vdrain_done_cnt_held", done_cnt, 0);
        check("vdrain_v_valid", int'(weight_v_valid), 1);
        check("vdrain_v_e0", int'(weight_v[0]), 208);
        check("vdrain_v_elast", int'(weight_v[ELEMS-1]), 213);
        check("vdrain_no_reads", rd_total, TOTAL_RD);
        @(posedge clk);
        #1 weight_v_ready = 1'b1;
        wait_done(50, "vdrain");
        repeat (3) @(negedge clk);
        check("vdrain_acc_v", acc[2], PER_STREAM);
        check("vdrain_done_cnt", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
